// File: rtl/riscv_fetch.sv
// Instruction-fetch front end: owns the PC, issues in-order word fetches and buffers responses for decode.
// Optional build macro FETCH_MISALIGN_EN turns misaligned redirects into a single faulting entry plus a request halt.
module riscv_fetch #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESETVEC = XLEN'('h8000_0000),
  parameter int              QDEPTH   = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  output logic [31:0]     fetch_instr,
  output logic            fetch_err
);

  localparam int AW = $clog2(QDEPTH);
  localparam int PW = AW + 1;
  localparam int DW = PW + 2;

  logic [XLEN-1:0] pc;
  logic [PW-1:0]   alloc_ptr;
  logic [PW-1:0]   fill_ptr;
  logic [PW-1:0]   read_ptr;
  logic [DW-1:0]   drop_cnt;
  logic            halted;

  logic [XLEN-1:0] q_pc    [QDEPTH];
  logic [31:0]     q_instr [QDEPTH];
  logic            q_err   [QDEPTH];

  logic [PW-1:0]   occ;
  logic            req_hs;
  logic            rsp_drop;
  logic            rsp_fill;
  logic            head_vld;
  logic            pop;
  logic            redir_mis;
  logic [XLEN-1:0] redir_pc_eff;

`ifdef FETCH_MISALIGN_EN
  assign redir_mis    = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redir_pc_eff = redirect_pc;
`else
  assign redir_mis    = 1'b0;
  assign redir_pc_eff = redirect_pc & ~XLEN'(3);
`endif

  assign occ            = alloc_ptr - read_ptr;
  assign imem_req_valid = !reset && !halted && (occ < PW'(QDEPTH));
  assign imem_req_addr  = pc;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_fill       = imem_rsp_valid && (drop_cnt == '0);

  assign head_vld    = (read_ptr != fill_ptr) && !redirect_valid;
  assign pop         = head_vld && fetch_ready;
  assign fetch_valid = head_vld;
  assign fetch_pc    = head_vld ? q_pc[read_ptr[AW-1:0]]    : '0;
  assign fetch_instr = head_vld ? q_instr[read_ptr[AW-1:0]] : '0;
  assign fetch_err   = head_vld ? q_err[read_ptr[AW-1:0]]   : 1'b0;

  // Control state: PC, queue pointers, drop counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESETVEC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      read_ptr  <= '0;
      drop_cnt  <= '0;
`ifdef FETCH_MISALIGN_EN
      halted    <= 1'b0;
`endif
    end else if (redirect_valid) begin
      pc        <= redir_pc_eff;
      alloc_ptr <= redir_mis ? PW'(1) : '0;
      fill_ptr  <= redir_mis ? PW'(1) : '0;
      read_ptr  <= '0;
      // Any response landing now is thrown away, whether it was already
      // marked for dropping or was one of the alloc-fill outstanding ones.
      drop_cnt  <= drop_cnt + DW'(alloc_ptr - fill_ptr) + DW'(req_hs) - DW'(imem_rsp_valid);
`ifdef FETCH_MISALIGN_EN
      halted    <= redir_mis;
`endif
    end else begin
      if (req_hs) begin
        alloc_ptr <= alloc_ptr + PW'(1);
        pc        <= pc + XLEN'(4);
      end
      if (rsp_fill) fill_ptr <= fill_ptr + PW'(1);
      if (rsp_drop) drop_cnt <= drop_cnt - DW'(1);
      if (pop)      read_ptr <= read_ptr + PW'(1);
    end
  end

`ifndef FETCH_MISALIGN_EN
  assign halted = 1'b0;
`endif

  // Queue payload: written on allocate/fill, never reset
  always_ff @(posedge clk) begin
    if (redirect_valid) begin
      if (redir_mis) begin
        q_pc[0]    <= redirect_pc;
        q_instr[0] <= '0;
        q_err[0]   <= 1'b1;
      end
    end else begin
      if (req_hs) q_pc[alloc_ptr[AW-1:0]] <= pc;
      if (rsp_fill) begin
        q_instr[fill_ptr[AW-1:0]] <= imem_rsp_data;
        q_err[fill_ptr[AW-1:0]]   <= imem_rsp_err;
      end
    end
  end

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch with an in-order instruction memory model (instr = ~addr[31:0]).
module tb_riscv_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_err = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        fetch_valid;
  logic        fetch_ready = 1'b1;
  logic [63:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        fetch_err;

  riscv_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_pc       (fetch_pc),
    .fetch_instr    (fetch_instr),
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          hs_cnt = 0;
  int          rsp_count = 0;
  int          err_idx = -1;
  logic        mem_hold = 1'b0;
  logic [63:0] pend_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: sample the handshake, take the edge, then advance the memory model.
  task automatic step();
    logic        hs;
    logic [63:0] a;
    logic [63:0] ra;
    #1;
    hs = imem_req_valid && imem_req_ready;
    a  = imem_req_addr;
    if (hs) hs_cnt++;
    @(posedge clk);
    #1;
    if (hs) pend_q.push_back(a);
    if (!mem_hold && pend_q.size() > 0) begin
      ra = pend_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~ra[31:0];
      imem_rsp_err   = (rsp_count == err_idx);
      rsp_count++;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    mem_hold       = 1'b0;
    pend_q.delete();
    rsp_count      = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    step();
    step();
  endtask

  logic [63:0] exp_pc;
  logic [63:0] first_pc;
  int          delivered;

  initial begin
    // Reset values and sequential streaming
    do_reset();
    check_eq("rst_req_valid", imem_req_valid, 0);
    check_eq("rst_req_addr", imem_req_addr, 64'h8000_0000);
    check_eq("rst_fetch_valid", fetch_valid, 0);
    check_eq("rst_fetch_pc", fetch_pc, 0);
    check_eq("rst_fetch_instr", fetch_instr, 0);
    check_eq("rst_fetch_err", fetch_err, 0);
    reset = 1'b0;
    #1;
    check_eq("c0_req_valid", imem_req_valid, 1);
    check_eq("c0_req_addr", imem_req_addr, 64'h8000_0000);
    step();
    check_eq("c1_fetch_valid", fetch_valid, 0);
    step();
    exp_pc = 64'h8000_0000;
    for (int i = 0; i < 6; i++) begin
      check_eq("seq_valid", fetch_valid, 1);
      check_eq("seq_pc", fetch_pc, exp_pc);
      check_eq("seq_instr", fetch_instr, {32'h0, ~exp_pc[31:0]});
      check_eq("seq_req_valid", imem_req_valid, 1);
      exp_pc = exp_pc + 64'd4;
      step();
    end

    // Mid-operation reset, then decode stall fills the queue
    reset = 1'b1;
    #1;
    check_eq("midrst_req_valid", imem_req_valid, 0);
    check_eq("midrst_fetch_valid", fetch_valid, 0);
    check_eq("midrst_req_addr", imem_req_addr, 64'h8000_0000);
    do_reset();
    fetch_ready = 1'b0;
    reset = 1'b0;
    hs_cnt = 0;
    repeat (8) step();
    check_eq("full_hs_cnt", hs_cnt, 4);
    check_eq("full_req_valid", imem_req_valid, 0);
    check_eq("full_head_pc", fetch_pc, 64'h8000_0000);
    fetch_ready = 1'b1;
    #1;
    check_eq("full_pre_pop", imem_req_valid, 0);
    step();
    fetch_ready = 1'b0;
    #1;
    check_eq("pop_resume_valid", imem_req_valid, 1);
    check_eq("pop_resume_addr", imem_req_addr, 64'h8000_0010);
    check_eq("pop_head_pc", fetch_pc, 64'h8000_0004);
    step();
    check_eq("refull_req_valid", imem_req_valid, 0);
    check_eq("refull_hs_cnt", hs_cnt, 5);

    // Redirect with three requests in flight
    do_reset();
    fetch_ready = 1'b1;
    mem_hold = 1'b1;
    reset = 1'b0;
    repeat (3) step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_1000;
    #1;
    check_eq("redir3_fetch_valid", fetch_valid, 0);
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    mem_hold = 1'b0;
    #1;
    check_eq("redir3_req_addr", imem_req_addr, 64'h8000_1000);
    exp_pc = 64'h8000_1000;
    first_pc = '0;
    delivered = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (fetch_valid) begin
        if (delivered == 0) first_pc = fetch_pc;
        check_eq("redir3_seq_pc", fetch_pc, exp_pc);
        check_eq("redir3_seq_instr", fetch_instr, {32'h0, ~exp_pc[31:0]});
        exp_pc = exp_pc + 64'd4;
        delivered++;
      end
      step();
    end
    check_eq("redir3_first_pc", first_pc, 64'h8000_1000);
    check_eq("redir3_delivered", delivered >= 3, 1);

    // Redirect coinciding with a request handshake and a response
    do_reset();
    fetch_ready = 1'b1;
    imem_req_ready = 1'b1;
    reset = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_2000;
    #1;
    check_eq("redirx_hs_pending", imem_req_valid, 1);
    step();
    redirect_valid = 1'b0;
    #1;
    check_eq("redirx_req_valid", imem_req_valid, 1);
    check_eq("redirx_req_addr", imem_req_addr, 64'h8000_2000);
    check_eq("redirx_c2_valid", fetch_valid, 0);
    step();
    check_eq("redirx_c3_valid", fetch_valid, 0);
    step();
    check_eq("redirx_c4_valid", fetch_valid, 1);
    check_eq("redirx_c4_pc", fetch_pc, 64'h8000_2000);
    check_eq("redirx_c4_instr", fetch_instr, 64'h7FFF_DFFF);

    // Access fault on the second response
    do_reset();
    err_idx = 1;
    reset = 1'b0;
    step();
    step();
    exp_pc = 64'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      check_eq("err_seq_pc", fetch_pc, exp_pc);
      check_eq("err_seq_err", fetch_err, (exp_pc == 64'h8000_0004));
      exp_pc = exp_pc + 64'd4;
      step();
    end
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_5000;
    #1;
    check_eq("redir_forces_invalid", fetch_valid, 0);
    step();
    redirect_valid = 1'b0;
    err_idx = -1;

`ifdef FETCH_MISALIGN_EN
    // Misaligned redirect yields one faulting entry and halts requests
    do_reset();
    imem_req_ready = 1'b0;
    fetch_ready = 1'b0;
    reset = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0002;
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    check_eq("mis_req_valid", imem_req_valid, 0);
    check_eq("mis_fetch_valid", fetch_valid, 1);
    check_eq("mis_fetch_pc", fetch_pc, 64'h8000_0002);
    check_eq("mis_fetch_instr", fetch_instr, 0);
    check_eq("mis_fetch_err", fetch_err, 1);
    fetch_ready = 1'b1;
    step();
    check_eq("mis_after_pop_valid", fetch_valid, 0);
    repeat (3) step();
    check_eq("mis_halt_req_valid", imem_req_valid, 0);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_3000;
    step();
    redirect_valid = 1'b0;
    #1;
    check_eq("mis_resume_valid", imem_req_valid, 1);
    check_eq("mis_resume_addr", imem_req_addr, 64'h8000_3000);
`else
    // Low redirect bits are ignored without the misalign feature
    do_reset();
    imem_req_ready = 1'b1;
    fetch_ready = 1'b1;
    reset = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_4002;
    step();
    redirect_valid = 1'b0;
    #1;
    check_eq("align_req_valid", imem_req_valid, 1);
    check_eq("align_req_addr", imem_req_addr, 64'h8000_4000);
    step();
    step();
    check_eq("align_fetch_valid", fetch_valid, 1);
    check_eq("align_fetch_pc", fetch_pc, 64'h8000_4000);
    check_eq("align_fetch_instr", fetch_instr, 64'h7FFF_BFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
